// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide unit for the E stage: computes results at accept time,
// holds them pending for a fixed busy window, then commits them to HI/LO.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic [31:0]    pend_hi_q, pend_lo_q;
   logic           pend_valid_q;
   logic           accept;
   logic           is_mdu_op, is_mul, is_div;
   logic           last_cycle;

   logic [63:0]    mul_a, mul_b, product;
   logic [31:0]    a_abs, b_abs, q_u, r_u, quo, rem;
   logic           div_signed;

   assign is_mdu_op  = (op != OP_NONE) && (op <= OP_MTLO);
   assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div     = (op == OP_DIV)  || (op == OP_DIVU);
   assign stall_req  = start && is_mdu_op && (busy || (cnt_q != '0));
   assign accept     = (state_q == IDLE) && start && !Req && !stall_req;
   assign last_cycle = (cnt_q <= CW'(1));

   // Signed multiply via sign extension to 64 bits; the low 64 bits of the
   // product are identical for signed and unsigned interpretations.
   always_comb begin
      if (op == OP_MULT) begin
         mul_a = {{32{rs_val[31]}}, rs_val};
         mul_b = {{32{rt_val[31]}}, rt_val};
      end else begin
         mul_a = {32'd0, rs_val};
         mul_b = {32'd0, rt_val};
      end
      product = mul_a * mul_b;
   end

   // Signed divide done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
   // without relying on signed-division corner behaviour.
   always_comb begin
      div_signed = (op == OP_DIV);
      a_abs = (div_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
      b_abs = (div_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
      if (b_abs != '0) begin
         q_u = a_abs / b_abs;
         r_u = a_abs % b_abs;
      end else begin
         q_u = '0;
         r_u = '0;
      end
      quo = (div_signed && (rs_val[31] ^ rt_val[31])) ? (~q_u + 32'd1) : q_u;
      rem = (div_signed && rs_val[31]) ? (~r_u + 32'd1) : r_u;
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept && (is_mul || is_div)) state_d = RUN;
         RUN:  if (last_cycle)                   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi           <= '0;
         lo           <= '0;
         cnt_q        <= '0;
         pend_hi_q    <= '0;
         pend_lo_q    <= '0;
         pend_valid_q <= 1'b0;
      end else if (state_q == IDLE) begin
         if (accept) begin
            if (is_mul) begin
               pend_hi_q    <= product[63:32];
               pend_lo_q    <= product[31:0];
               pend_valid_q <= 1'b1;
               cnt_q        <= CW'(MULT_CYCLES);
            end else if (is_div) begin
               pend_hi_q    <= rem;
               pend_lo_q    <= quo;
               pend_valid_q <= (rt_val != '0);
               cnt_q        <= CW'(DIV_CYCLES);
            end else if (op == OP_MTHI) begin
               hi <= rs_val;
            end else if (op == OP_MTLO) begin
               lo <= rs_val;
            end
         end
      end else begin
         cnt_q <= cnt_q - CW'(1);
         if (last_cycle) begin
            if (pend_valid_q) begin
               hi <= pend_hi_q;
               lo <= pend_lo_q;
            end
            pend_valid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (start && (op == OP_MFHI)) rd_data = hi;
      if (start && (op == OP_MFLO)) rd_data = lo;
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: busy window timing, arithmetic
// results, stall behaviour, flush handling and reset during a run.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Req = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        busy, stall_req;
   logic [31:0] hi, lo, rd_data;

   int checks = 0;
   int errors = 0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .Req(Req), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .stall_req(stall_req),
      .hi(hi), .lo(lo), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic r);
      start = 1'b1; op = o; rs_val = a; rt_val = b; Req = r;
      tick();
      start = 1'b0; op = 4'd0; Req = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall_req); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
   endtask

   task automatic test_mult();
      issue(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
      rs_val = 32'h12345; rt_val = 32'h777;
      for (int i = 0; i < 5; i++) begin
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy[%0d] got %0b want 1", i, busy); end
         tick();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_done got %0b want 0", busy); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo got %h want fffffffe", lo); end
      issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_done got %0b want 0", busy); end
      checks++; if (hi !== 32'h1) begin errors++; $display("FAIL multu_hi got %h want 00000001", hi); end
      checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", lo); end
   endtask

   task automatic test_div();
      issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy[%0d] got %0b want 1", i, busy); end
         tick();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_done got %0b want 0", busy); end
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
      issue(4'd4, 32'd7, 32'd0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divz_busy[%0d] got %0b want 1", i, busy); end
         tick();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divz_done got %0b want 0", busy); end
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL divz_lo got %h want fffffffd", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_hi got %h want ffffffff", hi); end
      issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo got %h want 80000000", lo); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi got %h want 00000000", hi); end
      issue(4'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      checks++; if (lo !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu_lo got %h want 7ffffffc", lo); end
      checks++; if (hi !== 32'h1) begin errors++; $display("FAIL divu_hi got %h want 00000001", hi); end
   endtask

   task automatic test_stall();
      issue(4'd1, 32'd3, 32'd5, 1'b0);
      start = 1'b1; op = 4'd6;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL mflo_stall[%0d] got %0b want 1", i, stall_req); end
         if (i == 2) begin
            op = 4'd0; #1;
            checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL addu_stall got %0b want 0", stall_req); end
            start = 1'b0; op = 4'd6; #1;
            checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL nostart_stall got %0b want 0", stall_req); end
            start = 1'b1;
         end
         tick();
      end
      #1;
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mflo_release got %0b want 0", stall_req); end
      checks++; if (rd_data !== 32'd15) begin errors++; $display("FAIL mflo_data got %h want 0000000f", rd_data); end
      op = 4'd5; #1;
      checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL mfhi_data got %h want 00000000", rd_data); end
      op = 4'd0; #1;
      checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL nop_data got %h want 00000000", rd_data); end
      start = 1'b0;
      tick();
   endtask

   task automatic test_mt_req();
      issue(4'd7, 32'hAAAA5555, 32'd0, 1'b0);
      checks++; if (hi !== 32'hAAAA5555) begin errors++; $display("FAIL mthi_first got %h want aaaa5555", hi); end
      issue(4'd7, 32'h12345678, 32'd0, 1'b1);
      checks++; if (hi !== 32'hAAAA5555) begin errors++; $display("FAIL mthi_req got %h want aaaa5555", hi); end
      issue(4'd7, 32'h12345678, 32'd0, 1'b0);
      checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi got %h want 12345678", hi); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0b want 0", busy); end
      issue(4'd1, 32'd9, 32'd9, 1'b1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_req_busy got %0b want 0", busy); end
      for (int i = 0; i < 6; i++) tick();
      checks++; if (lo !== 32'd15) begin errors++; $display("FAIL mult_req_lo got %h want 0000000f", lo); end
   endtask

   task automatic test_req_run();
      issue(4'd3, 32'd100, 32'd7, 1'b0);
      for (int i = 0; i < 10; i++) begin
         Req = (i == 2);
         #1;
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reqrun_busy[%0d] got %0b want 1", i, busy); end
         tick();
      end
      Req = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reqrun_done got %0b want 0", busy); end
      checks++; if (lo !== 32'd14) begin errors++; $display("FAIL reqrun_lo got %h want 0000000e", lo); end
      checks++; if (hi !== 32'd2) begin errors++; $display("FAIL reqrun_hi got %h want 00000002", hi); end
      issue(4'd3, 32'd50, 32'd3, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", busy); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midreset_hi got %h want 0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midreset_lo got %h want 0", lo); end
      for (int i = 0; i < 10; i++) tick();
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midreset_late_lo got %h want 0", lo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_late_busy got %0b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      issue(4'd1, 32'h00010000, 32'h00030003, 1'b0);
      start = 1'b1; op = 4'd8; rs_val = 32'hCAFEBABE;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL b2b_stall[%0d] got %0b want 1", i, stall_req); end
         tick();
      end
      #1;
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL b2b_release got %0b want 0", stall_req); end
      checks++; if (hi !== 32'h3) begin errors++; $display("FAIL b2b_prod_hi got %h want 00000003", hi); end
      checks++; if (lo !== 32'h00030000) begin errors++; $display("FAIL b2b_prod_lo got %h want 00030000", lo); end
      tick();
      start = 1'b0; op = 4'd0;
      checks++; if (lo !== 32'hCAFEBABE) begin errors++; $display("FAIL b2b_mtlo got %h want cafebabe", lo); end
      checks++; if (hi !== 32'h3) begin errors++; $display("FAIL b2b_hi got %h want 00000003", hi); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %0b want 0", busy); end
   endtask

   initial begin
      tick();
      test_reset();
      test_mult();
      test_div();
      test_stall();
      test_mt_req();
      test_req_run();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
